uart_tx: RTL
============

Name: uart_tx

Overview:
- UART transmit engine; sits directly downstream of the TX baud-rate tick generator and consumes its single-cycle oversampling tick (`s_tick`, 16 ticks per bit).
- Serialises one parallel byte per request into a frame of start bit, data bits LSB-first and stop bit(s) on the `tx` line.
- Reports completion to the upstream TX FIFO or host interface.

Parameters:
- DBIT, 8, number of data bits per frame; legal 5..8.
- SB_TICK, 16, stop-bit duration in ticks; 16 = 1 stop bit, 24 = 1.5, 32 = 2; legal values 16, 24 or 32 only.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- s_tick  input  1  oversampling tick from the baud generator; one clk cycle wide, 16 per bit period.
- tx_start  input  1  start request; sampled only in IDLE.
- din  input  8  byte to send; only bits [DBIT-1:0] are used; captured in the same cycle tx_start is accepted.
- tx_busy  output  1  high in every state except IDLE.
- tx_done_tick  output  1  one-cycle pulse when the final stop tick completes.
- tx  output  1  serial line; registered output, idle high.

Behaviour:
- Registers:
  - state (IDLE, START, DATA, STOP, plus PARITY when the optional feature is compiled in).
  - s_reg: 5-bit tick counter.
  - n_reg: 3-bit bit index.
  - b_reg: 8-bit shift register.
  - tx_reg: drives tx.
- Reset (async): state=IDLE, s_reg=0, n_reg=0, b_reg=0, tx_reg=1. Therefore tx=1, tx_busy=0, tx_done_tick=0.
- Reset mid-frame aborts the frame immediately. tx returns high asynchronously. No done pulse.
- IDLE:
  - tx_reg=1.
  - On tx_start=1: b_reg<=din, s_reg<=0, state<=START, tx_reg<=0 on the same edge. tx is low from the next cycle.
  - s_tick is ignored in IDLE.
- START:
  - On each s_tick: if s_reg==15, then s_reg<=0, n_reg<=0, state<=DATA, tx_reg<=b_reg[0]; else s_reg<=s_reg+1.
- DATA:
  - On each s_tick: if s_reg==15, then s_reg<=0 and b_reg<=b_reg>>1.
  - If n_reg==DBIT-1: state<=STOP and tx_reg<=1. Otherwise n_reg<=n_reg+1 and tx_reg<=next bit (b_reg[1]).
  - Else s_reg<=s_reg+1.
- STOP:
  - tx_reg=1.
  - On each s_tick: if s_reg==SB_TICK-1, then state<=IDLE and tx_done_tick=1 for that cycle only (Mealy on s_tick); else s_reg<=s_reg+1.
- Each bit is held exactly 16 ticks. The stop bit is held SB_TICK ticks.
- Frame length with the feature off is (1+DBIT)*16+SB_TICK ticks. Default: 160 ticks.
- tx_start while tx_busy=1 is ignored; no queuing.
- tx_start in the same cycle as s_tick in IDLE: the start is accepted. That s_tick is not counted; counting begins at the next tick.
- A new tx_start in the cycle after tx_done_tick is accepted, giving back-to-back frames with no idle gap beyond one clk.
- din is don't-care outside the accept cycle.
- The counters never wrap. s_reg resets to 0 at every bit boundary.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, lasting 16 ticks.
  - The parity bit is even parity of din[DBIT-1:0], computed and registered into p_reg at accept time.
  - The DATA exit goes to PARITY with tx_reg<=p_reg.
  - Frame = (2+DBIT)*16+SB_TICK ticks.
- Undefined: no PARITY state, no p_reg; behaviour exactly as above.

Decomposition:
- Shared package `uart_pkg`:
  - State enum `uart_tx_state_t`.
  - Constants `UART_OS_TICKS=16`, `UART_DBIT_DEF=8`, `UART_SB_TICK_DEF=16`.
  - The same package is reused by the receiver.
- No sub-module. The FSM and shift register form one unit. The baud generator stays a separate sibling, instanced at top level.

Test Plan:
- Default parameters, tick every 109 clk, tx_start with din=8'hA5 → tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks wide; tx_done_tick once after 160 ticks; tx_busy high throughout.
- tx_start with din=8'h3C, then tx_start pulsed again at tick 40 with din=8'hFF → the second request is ignored; only 0x3C is sent; exactly one done pulse.
- Two frames, 8'h00 then 8'hFF, with the second tx_start in the cycle after tx_done_tick → contiguous frames; stop bit is 16 ticks; no extra idle.
- SB_TICK=32, DBIT=7, din=8'h41 → 7 data bits 1,0,0,0,0,0,1; stop high for 32 ticks; done at tick 160.
- Reset asserted at tick 70 mid-DATA → tx=1 and tx_busy=0 immediately; no tx_done_tick; the next tx_start sends a full clean frame.
- UART_TX_PARITY_EN defined: din=8'hA5 (even weight) gives parity bit 0; din=8'h07 gives parity bit 1; frame is 176 ticks.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions (transmitter and receiver): state
//               encoding and oversampling/frame constants.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int UART_OS_TICKS    = 16;
   localparam int UART_DBIT_DEF    = 8;
   localparam int UART_SB_TICK_DEF = 16;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } uart_tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmit engine; start bit, DBIT data bits LSB-first,
//               optional even parity (UART_TX_PARITY_EN), SB_TICK-tick stop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
   import uart_pkg::*;
#(
   parameter int DBIT    = UART_DBIT_DEF,
   parameter int SB_TICK = UART_SB_TICK_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s_tick,
   input  logic       tx_start,
   input  logic [7:0] din,
   output logic       tx_busy,
   output logic       tx_done_tick,
   output logic       tx
);

   localparam logic [4:0] c_BIT_LAST  = 5'(UART_OS_TICKS - 1);
   localparam logic [4:0] c_STOP_LAST = 5'(SB_TICK - 1);
   localparam logic [2:0] c_DATA_LAST = 3'(DBIT - 1);

   uart_tx_state_t r_state, w_state_nx;
   logic [4:0]     r_s, w_s_nx;
   logic [2:0]     r_n, w_n_nx;
   logic [7:0]     r_b, w_b_nx;
   logic           r_tx, w_tx_nx;
`ifdef UART_TX_PARITY_EN
   logic           r_p, w_p_nx;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= TX_IDLE;
         r_s     <= '0;
         r_n     <= '0;
         r_b     <= '0;
         r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_p     <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nx;
         r_s     <= w_s_nx;
         r_n     <= w_n_nx;
         r_b     <= w_b_nx;
         r_tx    <= w_tx_nx;
`ifdef UART_TX_PARITY_EN
         r_p     <= w_p_nx;
`endif
      end
   end

   always_comb begin
      w_state_nx   = r_state;
      w_s_nx       = r_s;
      w_n_nx       = r_n;
      w_b_nx       = r_b;
      w_tx_nx      = r_tx;
`ifdef UART_TX_PARITY_EN
      w_p_nx       = r_p;
`endif
      tx_done_tick = 1'b0;

      case (r_state)
         TX_IDLE: begin
            w_tx_nx = 1'b1;
            // Any s_tick in the accept cycle is deliberately not counted.
            if (tx_start) begin
               w_b_nx     = din;
               w_s_nx     = '0;
               w_state_nx = TX_START;
               w_tx_nx    = 1'b0;
`ifdef UART_TX_PARITY_EN
               w_p_nx     = ^din[DBIT-1:0];
`endif
            end
         end

         TX_START: begin
            if (s_tick) begin
               if (r_s == c_BIT_LAST) begin
                  w_s_nx     = '0;
                  w_n_nx     = '0;
                  w_state_nx = TX_DATA;
                  w_tx_nx    = r_b[0];
               end else begin
                  w_s_nx = r_s + 5'd1;
               end
            end
         end

         TX_DATA: begin
            if (s_tick) begin
               if (r_s == c_BIT_LAST) begin
                  w_s_nx = '0;
                  w_b_nx = r_b >> 1;
                  if (r_n == c_DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                     w_state_nx = TX_PARITY;
                     w_tx_nx    = r_p;
`else
                     w_state_nx = TX_STOP;
                     w_tx_nx    = 1'b1;
`endif
                  end else begin
                     w_n_nx  = r_n + 3'd1;
                     w_tx_nx = r_b[1];
                  end
               end else begin
                  w_s_nx = r_s + 5'd1;
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         TX_PARITY: begin
            if (s_tick) begin
               if (r_s == c_BIT_LAST) begin
                  w_s_nx     = '0;
                  w_state_nx = TX_STOP;
                  w_tx_nx    = 1'b1;
               end else begin
                  w_s_nx = r_s + 5'd1;
               end
            end
         end
`endif

         TX_STOP: begin
            w_tx_nx = 1'b1;
            if (s_tick) begin
               if (r_s == c_STOP_LAST) begin
                  w_state_nx   = TX_IDLE;
                  tx_done_tick = 1'b1;
               end else begin
                  w_s_nx = r_s + 5'd1;
               end
            end
         end

         default: begin
            w_state_nx = TX_IDLE;
         end
      endcase
   end

   assign tx_busy = (r_state != TX_IDLE);
   assign tx      = r_tx;

endmodule
`default_nettype wire
